// File: rtl/multicycle_alu_pkg.sv
// multicycle_alu_pkg: shared ALU opcode header, FSM state encoding and shift-amount width.
package multicycle_alu_pkg;
    localparam int ALU_SHAMT_W = 5;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_BEQ = 4'd7;
    localparam logic [3:0] ALU_BNE = 4'd8;
    localparam logic [3:0] ALU_BLT = 4'd9;
    localparam logic [3:0] ALU_BGE = 4'd10;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/multicycle_alu_shifter.sv
// multicycle_alu_shifter: one-bit step shifter, or full barrel shifter when
// MULTICYCLE_ALU_BARREL_SHIFT_EN is defined.
module multicycle_alu_shifter #(
    parameter int W  = 32,
    parameter int SW = 5
) (
    input  logic [W-1:0]  value,
    input  logic          left,
    input  logic [SW-1:0] amount,
    output logic [W-1:0]  result
);
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
    assign result = left ? value << amount : value >> amount;
`else
    // A zero remaining amount means no shifting is left to do.
    assign result = (amount == '0) ? value : left ? value << 1 : value >> 1;
`endif
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: valid/ready execution unit with serial shifts and branch conditions.
// Define MULTICYCLE_ALU_BARREL_SHIFT_EN for single-cycle shifts.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_in_1,
    input  logic [XLEN-1:0] alu_in_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_bcond,
    output logic            illegal_op
);
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
    localparam bit SERIAL = 1'b0;
`else
    localparam bit SERIAL = 1'b1;
`endif
    state_e              state_q, state_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic                bcond_q, bcond_d;
    logic                ill_q, ill_d;
    logic [XLEN-1:0]     alu_val, sh_out;
    logic                bcond_v, legal, is_shift;
    logic [SHAMT_W-1:0]  shamt;
    assign shamt    = alu_in_2[SHAMT_W-1:0];
    assign is_shift = (alu_op == ALU_SLL) || (alu_op == ALU_SRL);
    // The accept cycle already performs the first shift step, so latency equals shamt.
    multicycle_alu_shifter #(.W(XLEN), .SW(SHAMT_W)) u_shifter (
        .value  (state_q == SHIFT ? res_q : alu_in_1),
        .left   (state_q == SHIFT ? dir_q : alu_op == ALU_SLL),
        .amount (state_q == SHIFT ? cnt_q : shamt),
        .result (sh_out)
    );
    always_comb begin
        alu_val = '0;
        bcond_v = 1'b0;
        legal   = 1'b1;
        case (alu_op)
            ALU_ADD: alu_val = alu_in_1 + alu_in_2;
            ALU_SUB: alu_val = alu_in_1 - alu_in_2;
            ALU_XOR: alu_val = alu_in_1 ^ alu_in_2;
            ALU_OR:  alu_val = alu_in_1 | alu_in_2;
            ALU_AND: alu_val = alu_in_1 & alu_in_2;
            ALU_SLL, ALU_SRL: alu_val = sh_out;
            ALU_BEQ: begin alu_val = alu_in_1 - alu_in_2; bcond_v = alu_in_1 == alu_in_2; end
            ALU_BNE: begin alu_val = alu_in_1 - alu_in_2; bcond_v = alu_in_1 != alu_in_2; end
            ALU_BLT: begin alu_val = alu_in_1 - alu_in_2; bcond_v = $signed(alu_in_1) < $signed(alu_in_2); end
            ALU_BGE: begin alu_val = alu_in_1 - alu_in_2; bcond_v = $signed(alu_in_1) >= $signed(alu_in_2); end
            default: legal = 1'b0;
        endcase
    end
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        bcond_d = bcond_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: if (in_valid) begin
                res_d   = alu_val;
                bcond_d = bcond_v;
                ill_d   = !legal;
                dir_d   = alu_op == ALU_SLL;
                cnt_d   = shamt - SHAMT_W'(1);
                state_d = (SERIAL && is_shift && shamt > SHAMT_W'(1)) ? SHIFT : DONE;
            end
            SHIFT: begin
                res_d   = sh_out;
                cnt_d   = cnt_q - SHAMT_W'(1);
                state_d = (cnt_q == SHAMT_W'(1)) ? DONE : SHIFT;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            bcond_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            bcond_q <= bcond_d;
            ill_q   <= ill_d;
        end
    end
    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign alu_result = res_q;
    assign alu_bcond  = bcond_q;
    assign illegal_op = ill_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: randomized and directed self-checking bench for multicycle_alu
// against a behavioural model of the op set and handshake latency.
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = '0;
    logic [31:0] alu_in_1 = '0;
    logic [31:0] alu_in_2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_result;
    logic        alu_bcond;
    logic        illegal_op;
    int n_tests = 0;
    int n_fail  = 0;

    multicycle_alu dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .alu_bcond(alu_bcond), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic bc, output logic il, output int lat);
        int sh;
        sh = int'(b % 32);
        r = 0; bc = 0; il = 0; lat = 1;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_XOR: r = a ^ b;
            ALU_OR:  r = a | b;
            ALU_AND: r = a & b;
            ALU_SLL: begin r = a << sh; if (!BARREL && sh > 0) lat = sh; end
            ALU_SRL: begin r = a >> sh; if (!BARREL && sh > 0) lat = sh; end
            ALU_BEQ: begin r = a - b; bc = (a == b); end
            ALU_BNE: begin r = a - b; bc = (a != b); end
            ALU_BLT: begin r = a - b; bc = (int'(a) < int'(b)); end
            ALU_BGE: begin r = a - b; bc = (int'(a) >= int'(b)); end
            default: il = 1;
        endcase
    endtask

    // Drives one op, wiggles ignored inputs while busy, returns what the DUT presented.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] r, output logic bc, output logic il);
        @(negedge clk);
        in_valid = 1; alu_op = op; alu_in_1 = a; alu_in_2 = b; out_ready = 0;
        @(posedge clk);
        #1;
        lat = 0;
        while (lat < 100) begin
            in_valid = 1'($urandom); alu_op = 4'($urandom); alu_in_1 = $urandom; alu_in_2 = $urandom;
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        r = alu_result; bc = alu_bcond; il = illegal_op;
        in_valid = 0; out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    task automatic test_reset();
        logic seen;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 0;
        n_tests++;
        if ({in_ready, out_valid, alu_result, alu_bcond, illegal_op} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b res=%h bc=%b il=%b, expected rdy=1 vld=0 res=0 bc=0 il=0",
                     in_ready, out_valid, alu_result, alu_bcond, illegal_op);
        end
        @(negedge clk);
        in_valid = 1; alu_op = ALU_SLL; alu_in_1 = 1; alu_in_2 = 20;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (4) @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_midop: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
        end
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: got out_valid seen=%b, expected 0", seen);
        end
    endtask

    task automatic test_directed(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] er, input logic ebc, input logic eil, input int elat);
        int lat; logic [31:0] r; logic bc, il;
        run_op(op, a, b, lat, r, bc, il);
        n_tests++;
        if (lat !== elat || r !== er || bc !== ebc || il !== eil) begin
            n_fail++;
            $display("FAIL %s: got lat=%0d res=%h bc=%b il=%b, expected lat=%0d res=%h bc=%b il=%b",
                     name, lat, r, bc, il, elat, er, ebc, eil);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1; alu_op = ALU_ADD; alu_in_1 = 3; alu_in_2 = 4; out_ready = 0;
        @(posedge clk);
        #1 alu_op = ALU_SUB; alu_in_1 = 10; alu_in_2 = 1;
        repeat (5) begin
            @(negedge clk);
            n_tests++;
            if ({out_valid, in_ready, alu_result} !== {1'b1, 1'b0, 32'd7}) begin
                n_fail++;
                $display("FAIL backpressure_hold: got vld=%b rdy=%b res=%h, expected vld=1 rdy=0 res=7",
                         out_valid, in_ready, alu_result);
            end
        end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL backpressure_handoff: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        n_tests++;
        if ({out_valid, alu_result} !== {1'b1, 32'd9}) begin
            n_fail++;
            $display("FAIL backpressure_second: got vld=%b res=%h, expected vld=1 res=9", out_valid, alu_result);
        end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    task automatic test_random();
        int lat, elat; logic [31:0] a, b, r, er; logic bc, il, ebc, eil; logic [3:0] op;
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            if (i % 4 == 0) b = a;
            model(op, a, b, er, ebc, eil, elat);
            run_op(op, a, b, lat, r, bc, il);
            n_tests++;
            if (lat !== elat || r !== er || bc !== ebc || il !== eil) begin
                n_fail++;
                $display("FAIL random op=%0d a=%h b=%h: got lat=%0d res=%h bc=%b il=%b, expected lat=%0d res=%h bc=%b il=%b",
                         op, a, b, lat, r, bc, il, elat, er, ebc, eil);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed("add_wrap", ALU_ADD, 32'hFFFFFFFF, 1, 32'h0, 0, 0, 1);
        test_directed("sub_wrap", ALU_SUB, 0, 1, 32'hFFFFFFFF, 0, 0, 1);
        test_directed("sll_31", ALU_SLL, 1, 31, 32'h80000000, 0, 0, BARREL ? 1 : 31);
        test_directed("srl_4", ALU_SRL, 32'h80000000, 4, 32'h08000000, 0, 0, BARREL ? 1 : 4);
        test_directed("sll_shamt0", ALU_SLL, 32'hDEADBEEF, 32, 32'hDEADBEEF, 0, 0, 1);
        test_directed("srl_1", ALU_SRL, 32'h80000001, 1, 32'h40000000, 0, 0, 1);
        test_directed("blt_signed", ALU_BLT, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 1, 0, 1);
        test_directed("bge_signed", ALU_BGE, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 0, 0, 1);
        test_directed("beq_equal", ALU_BEQ, 32'h1234, 32'h1234, 32'h0, 1, 0, 1);
        test_directed("bne_equal", ALU_BNE, 32'h1234, 32'h1234, 32'h0, 0, 0, 1);
        test_directed("illegal_f", 4'hF, 32'h55, 32'h66, 32'h0, 0, 1, 1);
        test_directed("illegal_b", 4'hB, 32'h55, 32'h66, 32'h0, 0, 1, 1);
        test_backpressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
